// File: rtl/fpu_result_wb_arbiter.sv
// FPU result write-back arbiter: per-unit holding slots, round-robin
// grant onto the single FP register-file write port, sticky fflags.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_src_valid/result/flags/dest_reg
//                         per-unit completion pulse and payload
//   o_src_hold            slot occupied; do not start that unit
//   o_wb_valid/i_wb_ready write-back handshake
//   o_wb_data/rd/flags/src
//                         presented result, zero when idle
//   i_fflags_clear        CSR write of fflags
//   o_fflags_acc          sticky OR of accepted result flags
//   o_overflow            sticky: a completion was dropped
//
// Build option: define FPU_WB_BYPASS_EN for a zero-latency path
// from i_src_* to o_wb_* while every slot is empty and unlocked.
module fpu_result_wb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int FP_WIDTH_D = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_SRC-1:0]           i_src_valid,
  input  logic [NUM_SRC*FP_WIDTH_D-1:0] i_src_result,
  input  logic [NUM_SRC*5-1:0]         i_src_flags,
  input  logic [NUM_SRC*5-1:0]         i_src_dest_reg,
  output logic [NUM_SRC-1:0]           o_src_hold,
  output logic                         o_wb_valid,
  input  logic                         i_wb_ready,
  output logic [FP_WIDTH_D-1:0]        o_wb_data,
  output logic [4:0]                   o_wb_rd,
  output logic [4:0]                   o_wb_flags,
  output logic [$clog2(NUM_SRC)-1:0]   o_wb_src,
  input  logic                         i_fflags_clear,
  output logic [4:0]                   o_fflags_acc,
  output logic                         o_overflow
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int W  = FP_WIDTH_D;

  logic [NUM_SRC-1:0] full;
  logic [W-1:0]       slot_data  [NUM_SRC];
  logic [4:0]         slot_flags [NUM_SRC];
  logic [4:0]         slot_rd    [NUM_SRC];

  logic [SW-1:0]      rr_ptr;
  logic [SW-1:0]      lock_idx;
  logic               lock;

  logic [NUM_SRC-1:0] req;
  logic [SW-1:0]      grant;
  logic               byp;
  logic               accept;
  logic [W-1:0]       g_data;
  logic [4:0]         g_flags;
  logic [4:0]         g_rd;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] thru;

  // First requester after ptr, wrapping modulo NUM_SRC.
  function automatic logic [SW-1:0] rr_pick(
    input logic [NUM_SRC-1:0] r,
    input logic [SW-1:0]      ptr
  );
    logic [SW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && r[idx]) begin
        pick  = SW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    byp = 1'b0;
    req = full;
`ifdef FPU_WB_BYPASS_EN
    if (~|full && !lock) begin
      byp = 1'b1;
      req = i_src_valid;
    end
`endif
    grant   = lock ? lock_idx : rr_pick(req, rr_ptr);
    g_data  = slot_data[grant];
    g_flags = slot_flags[grant];
    g_rd    = slot_rd[grant];
`ifdef FPU_WB_BYPASS_EN
    if (byp) begin
      g_data  = i_src_result[int'(grant)*W +: W];
      g_flags = i_src_flags[int'(grant)*5 +: 5];
      g_rd    = i_src_dest_reg[int'(grant)*5 +: 5];
    end
`endif
  end

  // A locked grant always points at a full slot, so |req covers it.
  assign o_wb_valid = |req;
  assign accept     = o_wb_valid & i_wb_ready;

  assign o_wb_data  = o_wb_valid ? g_data  : '0;
  assign o_wb_flags = o_wb_valid ? g_flags : '0;
  assign o_wb_rd    = o_wb_valid ? g_rd    : '0;
  assign o_wb_src   = o_wb_valid ? grant   : '0;
  assign o_src_hold = full;

  // pop: granted slot drains; thru: bypassed source is never stored.
  always_comb begin
    pop  = '0;
    thru = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]  = accept & ~byp & (grant == SW'(i));
      thru[i] = accept &  byp & (grant == SW'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full         <= '0;
      rr_ptr       <= SW'(NUM_SRC - 1);
      lock         <= 1'b0;
      lock_idx     <= '0;
      o_fflags_acc <= '0;
      o_overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i_src_valid[i] && !thru[i]) begin
          // Refill in the accept cycle is legal; otherwise drop.
          if (!full[i] || pop[i]) begin
            full[i]       <= 1'b1;
            slot_data[i]  <= i_src_result[i*W +: W];
            slot_flags[i] <= i_src_flags[i*5 +: 5];
            slot_rd[i]    <= i_src_dest_reg[i*5 +: 5];
          end else begin
            o_overflow <= 1'b1;
          end
        end else if (pop[i]) begin
          full[i] <= 1'b0;
        end
      end

      if (accept) begin
        lock   <= 1'b0;
        rr_ptr <= grant;
      end else if (o_wb_valid) begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end

      // Clear takes effect before the OR of the accepted flags.
      if (accept) begin
        o_fflags_acc <= (i_fflags_clear ? 5'b0 : o_fflags_acc)
                        | g_flags;
      end else if (i_fflags_clear) begin
        o_fflags_acc <= '0;
      end
    end
  end

endmodule
